instr_fetch_unit: RTL and testbench

Instruction fetch front end that consumes the program counter and produces its next value. Every cycle it drives `PC_Next` into the PC register and fetches the word at `PC` from instruction memory over a request/grant/response handshake. Fetched words go into a small FIFO that feeds decode through a valid/ready handshake. Taken-branch redirects flush the FIFO and discard in-flight responses.

---
 rtl/instr_fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch front end. Produces the next PC, fetches the
//            word at PC over a req/gnt/rvalid memory handshake, and buffers
//            fetched words in a small FIFO that feeds decode through a
//            valid/ready handshake. Taken branches flush the FIFO and
//            discard any in-flight response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1  clock, all state updates on posedge
//   rst            in   1  synchronous reset, active low
//   PC             in  32  current PC from the PC register
//   PC_Next        out 32  next PC into the PC register (combinational)
//   branch_taken   in   1  redirect strobe
//   branch_target  in  32  redirect address
//   imem_req       out  1  fetch request
//   imem_addr      out 32  fetch address (equals PC)
//   imem_gnt       in   1  memory accepts the request
//   imem_rvalid    in   1  read data valid
//   imem_rdata     in  32  instruction word
//   instr_valid    out  1  buffer non-empty
//   instr          out 32  head instruction
//   instr_pc       out 32  PC of the head instruction
//   instr_ready    in   1  decode consumes the head
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] PC_Next,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned     c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_CNT_FULL = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    localparam logic [1:0] c_ST_REQ  = 2'd0;  // free to issue a request
    localparam logic [1:0] c_ST_RESP = 2'd1;  // one request outstanding
    localparam logic [1:0] c_ST_IDLE = 2'd2;  // buffer full, waiting for a pop

    logic [1:0]      r_state;
    logic            r_drop;
    logic [31:0]     r_req_pc;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [31:0]     r_fifo_instr [DEPTH];
    logic [31:0]     r_fifo_pc    [DEPTH];

    logic [1:0]      w_state_nxt;
    logic            w_drop_nxt;
    logic [31:0]     w_req_pc_nxt;
    logic [c_AW-1:0] w_wr_ptr_nxt;
    logic [c_AW-1:0] w_rd_ptr_nxt;
    logic [c_AW:0]   w_count_nxt;

    logic w_grant;
    logic w_push;
    logic w_pop;
    logic w_resp;

    // ------------------------------------------------------------------
    // Handshake outputs and datapath
    // ------------------------------------------------------------------
    always_comb begin
        // A redirect cycle never requests: the address is about to change.
        imem_req    = rst & (r_state == c_ST_REQ) & ~branch_taken;
        imem_addr   = PC;
        w_grant     = imem_req & imem_gnt;

        instr_valid = rst & (|r_count);
        instr       = r_fifo_instr[r_rd_ptr];
        instr_pc    = r_fifo_pc[r_rd_ptr];

        // A redirect flushes the buffer, so a same-cycle pop is moot.
        w_pop       = instr_valid & instr_ready & ~branch_taken;
        w_resp      = (r_state == c_ST_RESP) & imem_rvalid;
        w_push      = w_resp & ~r_drop & ~branch_taken;

        if (!rst) begin
            PC_Next = 32'd0;
        end else if (branch_taken) begin
            PC_Next = branch_target;
        end else if (w_grant) begin
            PC_Next = PC + 32'd4;
        end else begin
            PC_Next = PC;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_drop_nxt   = r_drop;
        w_req_pc_nxt = r_req_pc;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;

        if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end

        if (branch_taken) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end

        // The flushed count makes every redirect land in REQ unless a
        // response is still owed, in which case the drop flag swallows it.
        case (r_state)
            c_ST_REQ: begin
                if (w_grant) begin
                    w_req_pc_nxt = PC;
                    w_state_nxt  = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (imem_rvalid) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = (w_count_nxt < c_CNT_FULL) ? c_ST_REQ : c_ST_IDLE;
                end else if (branch_taken) begin
                    w_drop_nxt = 1'b1;
                end
            end
            c_ST_IDLE: begin
                if (w_count_nxt < c_CNT_FULL) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            default: begin
                w_state_nxt = c_ST_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_ST_REQ;
            r_drop       <= 1'b0;
            r_req_pc     <= 32'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fifo_instr <= '{default: 32'd0};
            r_fifo_pc    <= '{default: 32'd0};
        end else begin
            r_state  <= w_state_nxt;
            r_drop   <= w_drop_nxt;
            r_req_pc <= w_req_pc_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= imem_rdata;
                r_fifo_pc[r_wr_ptr]    <= r_req_pc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit with an external PC
//            register, a latency-configurable memory responder and a
//            queue-based reference of the fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC = 32'h0000_1234;
    logic [31:0] PC_Next;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    // PC register outside the unit
    always @(posedge clk) PC <= PC_Next;

    instr_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC            (PC),
        .PC_Next       (PC_Next),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: an outstanding-request flag, a drop flag and a queue of
    // buffered {instr, pc}. Requests are allowed whenever nothing is owed
    // and the queue has room.
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic        m_busy = 1'b0;
    logic        m_drop = 1'b0;
    logic [31:0] m_pend_pc = 32'd0;
    logic        m_exp_req;

    logic        cur_rst, cur_gnt, cur_rv, cur_rdy, cur_br;
    logic [31:0] cur_rdata;

    // memory responder
    logic        resp_pend = 1'b0;
    int          resp_delay = 0;
    int          lat_max = 0;
    logic [31:0] last_gnt_addr = 32'd0;

    task automatic apply(input logic a_rst, input logic a_gnt, input logic a_rv,
                         input logic a_rdy, input logic a_br, input logic [31:0] a_tgt);
        logic [31:0] exp_next;
        logic        exp_v;
        @(negedge clk);
        rst           = a_rst;
        imem_gnt      = a_gnt;
        imem_rvalid   = a_rv;
        imem_rdata    = a_rv ? mem_word(last_gnt_addr) : $urandom;
        instr_ready   = a_rdy;
        branch_taken  = a_br;
        branch_target = a_tgt;
        cur_rst = a_rst; cur_gnt = a_gnt; cur_rv = a_rv; cur_rdy = a_rdy; cur_br = a_br;
        cur_rdata = imem_rdata;
        #1;
        m_exp_req = a_rst && !m_busy && (m_q.size() < DEPTH) && !a_br;
        if (!a_rst)                    exp_next = 32'd0;
        else if (a_br)                 exp_next = a_tgt;
        else if (m_exp_req && a_gnt)   exp_next = PC + 32'd4;
        else                           exp_next = PC;
        exp_v = a_rst && (m_q.size() > 0);
        chk("imem_req", 32'(imem_req), 32'(m_exp_req));
        chk("imem_addr", imem_addr, PC);
        chk("PC_Next", PC_Next, exp_next);
        chk("instr_valid", 32'(instr_valid), 32'(exp_v));
        if (exp_v) begin
            chk("instr", instr, m_q[0].ins);
            chk("instr_pc", instr_pc, m_q[0].pc);
        end
    endtask

    task automatic commit();
        logic act_grant;
        ent_t e;
        act_grant = imem_req && imem_gnt;
        if (!cur_rst) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_q.delete();
        end else if (cur_br) begin
            m_q.delete();
            if (m_busy && cur_rv) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end else if (m_busy) begin
                m_drop = 1'b1;
            end
        end else begin
            if (m_q.size() > 0 && cur_rdy) void'(m_q.pop_front());
            if (m_busy && cur_rv) begin
                if (!m_drop) begin
                    e.ins = cur_rdata;
                    e.pc  = m_pend_pc;
                    m_q.push_back(e);
                end
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
            if (m_exp_req && cur_gnt) begin
                m_busy    = 1'b1;
                m_pend_pc = PC;
            end
        end
        if (cur_rv) resp_pend = 1'b0;
        else if (resp_pend && resp_delay > 0) resp_delay--;
        if (!cur_rst) resp_pend = 1'b0;
        if (act_grant) begin
            resp_pend     = 1'b1;
            resp_delay    = int'($urandom_range(lat_max));
            last_gnt_addr = imem_addr;
        end
        @(posedge clk);
    endtask

    task automatic run_auto(input int n, input int gnt_pct, input int rdy_pct,
                            input int br_pct, input int rst_pct);
        for (int i = 0; i < n; i++) begin
            apply(int'($urandom_range(99)) >= rst_pct,
                  int'($urandom_range(99)) < gnt_pct,
                  resp_pend && (resp_delay == 0),
                  int'($urandom_range(99)) < rdy_pct,
                  int'($urandom_range(99)) < br_pct,
                  $urandom & 32'hFFFF_FFFC);
            commit();
        end
    endtask

    typedef struct {
        logic        rst, gnt, rv, rdy, br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_next;
        logic        e_valid;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic g, input logic v, input logic y,
                                input logic b, input logic [31:0] t, input logic eq,
                                input logic [31:0] en, input logic ev, input logic [31:0] ep);
        vec_t x;
        x.rst = r; x.gnt = g; x.rv = v; x.rdy = y; x.br = b; x.tgt = t;
        x.e_req = eq; x.e_next = en; x.e_valid = ev; x.e_ipc = ep;
        return x;
    endfunction

    initial begin
        //               rst gnt rv rdy br tgt          req next          vld ipc
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,     1, 32'h4,     0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,     0, 32'h4,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,     1, 32'h8,     1, 32'h0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,     0, 32'h8,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,     1, 32'hC,     1, 32'h4));
        tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,     0, 32'hC,     0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,     1, 32'h10,    1, 32'h8));
        tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,     0, 32'h10,    0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,     1, 32'h14,    1, 32'hC));
        // redirect while the fetch of 0x10 is outstanding
        tbl.push_back(mk(1, 1, 0, 1, 1, 32'h100,   0, 32'h100,   0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,     0, 32'h100,   0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,     1, 32'h104,   0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 32'h0,     0, 32'h104,   0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,     1, 32'h108,   1, 32'h100));
        // redirect together with rvalid and instr_ready
        tbl.push_back(mk(1, 1, 1, 1, 1, 32'h200,   0, 32'h200,   1, 32'h100));
        tbl.push_back(mk(1, 1, 0, 1, 0, 32'h0,     1, 32'h204,   0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].gnt, tbl[i].rv, tbl[i].rdy, tbl[i].br, tbl[i].tgt);
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_pc_next", i), PC_Next, tbl[i].e_next);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
                chk($sformatf("tbl%0d_instr", i), instr, mem_word(tbl[i].e_ipc));
            end
            commit();
        end

        // Backpressure: two responses fill the buffer, then fetch stops at 8
        lat_max = 0;
        apply(0, 1, 0, 0, 0, 32'h0); commit();
        run_auto(4, 100, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 32'h0);
        chk("bp_idle_req", 32'(imem_req), 32'd0);
        chk("bp_pc_held", PC, 32'h8);
        chk("bp_head_pc", instr_pc, 32'h0);
        commit();
        run_auto(3, 100, 0, 0, 0);
        apply(1, 1, 0, 1, 0, 32'h0);
        chk("bp_pop_req", 32'(imem_req), 32'd0);
        commit();
        apply(1, 1, 0, 1, 0, 32'h0);
        chk("bp_resume_req", 32'(imem_req), 32'd1);
        chk("bp_resume_addr", imem_addr, 32'h8);
        commit();
        run_auto(12, 100, 100, 0, 0);

        // Grant stall: request and address hold, PC holds
        apply(0, 0, 0, 1, 0, 32'h0); commit();
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 1, 0, 32'h0);
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, 32'h0);
            chk("stall_pc_next", PC_Next, PC);
            commit();
        end
        apply(1, 1, 0, 1, 0, 32'h0); commit();

        // Reset while a response is owed; the late rvalid must be ignored
        apply(0, 1, 0, 1, 0, 32'h0);
        chk("rst_pc_next", PC_Next, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        commit();
        apply(1, 0, 1, 1, 0, 32'h0);
        chk("stale_req", 32'(imem_req), 32'd1);
        commit();
        apply(1, 0, 0, 1, 0, 32'h0);
        chk("stale_ignored", 32'(instr_valid), 32'd0);
        commit();

        // Wrap-around from the top word
        apply(1, 0, 0, 1, 1, 32'hFFFF_FFFC);
        chk("wrap_target", PC_Next, 32'hFFFF_FFFC);
        commit();
        apply(1, 1, 0, 1, 0, 32'h0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_next", PC_Next, 32'h0);
        commit();
        apply(1, 1, 1, 1, 0, 32'h0); commit();
        apply(1, 1, 0, 1, 0, 32'h0);
        chk("wrap_next_fetch", imem_addr, 32'h0);
        chk("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
        commit();

        // Random traffic
        lat_max = 3;
        run_auto(3000, 70, 60, 5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
